seq_pattern_detect: RTL and testbench
=====================================

// Module: seq_pattern_detect
// PURPOSE
//   Serial pattern detector downstream of the state-sequencer FSMs. Samples a
//   1-bit stream qualified by a valid strobe and compares a sliding window against
//   a fixed PAT_LEN-bit pattern. Emits a 1-cycle match pulse and keeps a
//   saturating match count for status and debug readout.
// PARAMETERS
//   PAT_LEN  4        pattern length in bits, 2..16
//   PATTERN  4'b1101  target pattern; MSB is the first bit received
//   OVERLAP  1        1: overlapping matches allowed; 0: window restarts after a match
//   CNT_W    8        match counter width, >= 2
// PORTS
//   clk_i        in   1       single clock; all state updates on the rising edge
//   rst_n_i      in   1       asynchronous active-low reset
//   bit_i        in   1       serial data bit
//   bit_valid_i  in   1       bit_i is accepted in any cycle this is high
//   clear_i      in   1       synchronous clear of window, FSM and counter
//   match_o      out  1       1-cycle pulse, cycle after the completing bit is accepted
//   match_cnt_o  out  CNT_W   number of matches since reset/clear, saturating
//   cnt_sat_o    out  1       sticky flag: counter reached all-ones
//   armed_o      out  1       high while the FSM is in HUNT
// BEHAVIOUR
//   Reset (rst_n_i low, async): hist=0, fill=0, state=FILL, match_o=0,
//     match_cnt_o=0, cnt_sat_o=0, armed_o=0. Reset takes effect mid-stream with
//     no pending pulse; a partial window is discarded.
//   Window: on an accepted bit, hist <= {hist[PAT_LEN-2:0], bit_i}. Cycles with
//     bit_valid_i=0 leave hist, fill, state and the counter unchanged.
//   cand = {hist[PAT_LEN-2:0], bit_i} is the window including the incoming bit.
//   FSM, 2 states, registered:
//     FILL: fill counts accepted bits, saturating at PAT_LEN-1. On an accepted bit
//       with fill==PAT_LEN-2, go to HUNT. armed_o=0. No comparison is made.
//     HUNT: each accepted bit is compared. hit = (cand==PATTERN). armed_o=1.
//       On hit with OVERLAP=1, stay in HUNT.
//       On hit with OVERLAP=0, go to FILL with fill=0; the completing bit does not
//       start the next window.
//   match_o: registered; asserts the cycle after a hit and stays high for exactly
//     1 cycle per hit. Back-to-back hits (e.g. PATTERN all-ones, OVERLAP=1) give
//     consecutive high cycles.
//   Counter: increments by 1 on each hit, in the same edge that sets match_o.
//     Holds at 2^CNT_W-1. cnt_sat_o sets on the edge the count reaches all-ones
//     and stays set until clear or reset.
//   clear_i (sync): next edge sets hist=0, fill=0, state=FILL, match_o=0, count=0,
//     sat=0. clear_i wins over a simultaneous bit_valid_i; that bit is dropped and
//     cannot produce a hit.
//   Latency: completing bit accepted at edge N -> match_o high in the cycle
//     following edge N and counter updated at edge N.
// STRUCTURE
//   Shared include seq_defs.vh holds the FSM state encodings (ST_FILL=1'b0,
//     ST_HUNT=1'b1) and the default pattern constants. The same encodings are
//     reused by the other sequencer blocks.
//   Sub-module sat_counter #(W): inc and clr inputs; val and sat outputs; async
//     active-low reset. It implements the match counter and the sticky flag.
//   Top level holds the window shift register, the fill counter, the FSM and the
//     match_o register.
// TESTING  (PAT_LEN=4, PATTERN=4'b1101, CNT_W=8 unless stated)
//   1 OVERLAP=1, stream 1,1,0,1,1,0,1 with valid every cycle
//     -> match_o pulses after bits 4 and 7; match_cnt_o=2.
//   2 OVERLAP=0, same stream
//     -> only 1 pulse, after bit 4; match_cnt_o=1; armed_o drops for 3 accepted bits.
//   3 Stream 1,1,0,1 with bit_valid_i low for 3 cycles between each bit,
//     bit_i toggling in the gaps -> exactly 1 pulse, after the 4th valid bit.
//   4 CNT_W=3, OVERLAP=1, stream 1101 followed by 101 repeated
//     -> count goes 1..7 then holds at 7; cnt_sat_o sets at 7; 8th hit still pulses
//     match_o.
//   5 clear_i asserted in the same cycle as the completing valid '1' of 1101
//     -> no pulse, count=0, armed_o=0; then a fresh 1101 -> 1 pulse.
//   6 rst_n_i pulsed low asynchronously mid-window after 1,1,0
//     -> outputs 0 immediately; a following 1 does not match; a full 1101 then matches.

Source files
------------

// File: rtl/seq_pattern_detect_pkg.sv
// Shared definitions for the sequencer blocks: FSM state encodings and the
// default pattern-detector constants.
package seq_pattern_detect_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HUNT = 1'b1
    } seq_state_t;

    localparam int unsigned DEF_PAT_LEN = 4;
    localparam logic [3:0]  DEF_PATTERN = 4'b1101;
    localparam bit          DEF_OVERLAP = 1'b1;
    localparam int unsigned DEF_CNT_W   = 8;

endpackage

// File: rtl/seq_pattern_detect_sat_counter.sv
// Saturating event counter with a sticky "reached all-ones" flag.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] val,
    output logic         sat
);

    localparam logic [W-1:0] TOP_MINUS_ONE = {{(W-1){1'b1}}, 1'b0};

    // Count up on inc, hold at all-ones; clear dominates; flag sets as the top is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            val <= '0;
            sat <= 1'b0;
        end else if (inc && (val != '1)) begin
            val <= val + 1'b1;
            if (val == TOP_MINUS_ONE) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_pattern_detect.sv
// Serial pattern detector: sliding window over a valid-qualified bit stream,
// 1-cycle match pulse and a saturating match counter.
module seq_pattern_detect
    import seq_pattern_detect_pkg::*;
#(
    parameter int unsigned        PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter bit                 OVERLAP = DEF_OVERLAP,
    parameter int unsigned        CNT_W   = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             bit_i,
    input  logic             bit_valid_i,
    input  logic             clear_i,
    output logic             match_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             cnt_sat_o,
    output logic             armed_o
);

    localparam int unsigned        FILL_W    = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(PAT_LEN - 2);
    localparam logic [FILL_W-1:0]  FILL_MAX  = FILL_W'(PAT_LEN - 1);

    seq_state_t          state;
    seq_state_t          state_next;
    // Only the newest PAT_LEN-1 bits of history ever reach the comparator,
    // so the oldest bit of the full-width window is not stored.
    logic [PAT_LEN-2:0]  hist;
    logic [FILL_W-1:0]   fill;
    logic [PAT_LEN-1:0]  cand;
    logic                accept;
    logic                hit;

    // A bit arriving with clear is dropped and can never complete a match
    assign accept = bit_valid_i && !clear_i;
    assign cand   = {hist, bit_i};
    assign hit    = accept && (state == ST_HUNT) && (cand == PATTERN);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave FILL once the window is full, restart after a hit when not overlapping
    always_comb begin
        state_next = state;
        if (clear_i) begin
            state_next = ST_FILL;
        end else if (accept) begin
            case (state)
                ST_FILL: if (fill == FILL_LAST) state_next = ST_HUNT;
                ST_HUNT: if (hit && !OVERLAP)   state_next = ST_FILL;
                default: state_next = ST_FILL;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        armed_o = (state == ST_HUNT);
    end

    // Window shift register, advances on every accepted bit
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hist <= '0;
        end else if (clear_i) begin
            hist <= '0;
        end else if (accept) begin
            hist <= cand[PAT_LEN-2:0];
        end
    end

    // Fill counter: accepted bits since the window restarted, saturating
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fill <= '0;
        end else if (clear_i) begin
            fill <= '0;
        end else if (accept) begin
            if (hit && !OVERLAP) begin
                fill <= '0;
            end else if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Match pulse, one cycle per hit
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            match_o <= 1'b0;
        end else begin
            match_o <= hit;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .inc   (hit),
        .clr   (clear_i),
        .val   (match_cnt_o),
        .sat   (cnt_sat_o)
    );

endmodule

// File: tb/tb_seq_pattern_detect.sv
// Bench for seq_pattern_detect: three configurations driven by one stream,
// each checked every cycle against a behavioural model, plus directed cases.
module tb_seq_pattern_detect;

    logic clk_i       = 1'b0;
    logic rst_n_i     = 1'b0;
    logic bit_i       = 1'b0;
    logic bit_valid_i = 1'b0;
    logic clear_i     = 1'b0;

    logic       m_a, m_b, m_c;
    logic       s_a, s_b, s_c;
    logic       ar_a, ar_b, ar_c;
    logic [7:0] cnt_a, cnt_b;
    logic [2:0] cnt_c;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned pulses[3] = '{0, 0, 0};

    always #5 clk_i = ~clk_i;

    // a: defaults, b: non-overlapping, c: 3-bit counter
    seq_pattern_detect #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
        .clear_i(clear_i), .match_o(m_a), .match_cnt_o(cnt_a), .cnt_sat_o(s_a), .armed_o(ar_a));
    seq_pattern_detect #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
        .clear_i(clear_i), .match_o(m_b), .match_cnt_o(cnt_b), .cnt_sat_o(s_b), .armed_o(ar_b));
    seq_pattern_detect #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(3)) dut_c (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
        .clear_i(clear_i), .match_o(m_c), .match_cnt_o(cnt_c), .cnt_sat_o(s_c), .armed_o(ar_c));

    // ---------------- behavioural model ----------------
    // seen: accepted bits since the window restarted; win: last 4 accepted bits
    localparam int unsigned PLEN = 4;
    localparam int unsigned PAT  = 13;

    int unsigned seen[3] = '{0, 0, 0};
    int unsigned win[3]  = '{0, 0, 0};
    int unsigned mcnt[3] = '{0, 0, 0};
    bit          mmatch[3] = '{0, 0, 0};
    bit          msat[3]   = '{0, 0, 0};

    function automatic bit ovl(int i);
        return i != 1;
    endfunction

    function automatic int unsigned cmax(int i);
        return (i == 2) ? 7 : 255;
    endfunction

    always @(posedge clk_i or negedge rst_n_i) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n_i || clear_i) begin
                seen[i] = 0; win[i] = 0; mcnt[i] = 0; mmatch[i] = 0; msat[i] = 0;
            end else begin
                mmatch[i] = 0;
                if (bit_valid_i) begin
                    win[i] = ((win[i] << 1) | int'(bit_i)) & 15;
                    if (seen[i] >= PLEN - 1 && win[i] == PAT) begin
                        mmatch[i] = 1;
                        if (mcnt[i] < cmax(i)) mcnt[i] = mcnt[i] + 1;
                        msat[i] = (mcnt[i] == cmax(i));
                        if (!ovl(i)) seen[i] = 0;
                    end else if (seen[i] < PLEN - 1) begin
                        seen[i] = seen[i] + 1;
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] t=%0t actual=%0d required=%0d", name, idx, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [31:0] dm[3], dc[3], ds[3], da[3];
        dm = '{32'(m_a), 32'(m_b), 32'(m_c)};
        dc = '{32'(cnt_a), 32'(cnt_b), 32'(cnt_c)};
        ds = '{32'(s_a), 32'(s_b), 32'(s_c)};
        da = '{32'(ar_a), 32'(ar_b), 32'(ar_c)};
        for (int i = 0; i < 3; i++) begin
            chk("match", i, dm[i], 32'(mmatch[i]));
            chk("count", i, dc[i], mcnt[i]);
            chk("sat", i, ds[i], 32'(msat[i]));
            chk("armed", i, da[i], 32'(seen[i] >= PLEN - 1));
            if (dm[i] == 32'd1) pulses[i] = pulses[i] + 1;
        end
    endtask

    // Drive one cycle of inputs; compare at the falling edge; return just after the rising edge
    task automatic cycle(input logic b, input logic v, input logic c);
        bit_i = b; bit_valid_i = v; clear_i = c;
        @(negedge clk_i);
        compare_all();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) cycle(bits[k], 1'b1, 1'b0);
    endtask

    task automatic async_reset_pulse();
        #1 rst_n_i = 1'b0;
        #1;
    endtask

    int unsigned p0[3];
    logic tog;

    initial begin
        // reset state
        @(posedge clk_i);
        #1;
        chk("rst_match", 0, 32'(m_a), 0);
        chk("rst_count", 0, 32'(cnt_a), 0);
        chk("rst_sat", 0, 32'(s_a), 0);
        chk("rst_armed", 0, 32'(ar_a), 0);
        rst_n_i = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);

        // overlapping vs non-overlapping on 1101101
        cycle(1'b0, 1'b0, 1'b1);
        p0 = pulses;
        send_bits(16'b1101, 4);
        cycle(1'b1, 1'b1, 1'b0);
        chk("novl_armed_drop", 1, 32'(ar_b), 0);
        send_bits(16'b01, 2);
        cycle(1'b0, 1'b0, 1'b0);
        chk("ovl_count", 0, 32'(cnt_a), 2);
        chk("ovl_pulses", 0, pulses[0] - p0[0], 2);
        chk("novl_count", 1, 32'(cnt_b), 1);
        chk("novl_pulses", 1, pulses[1] - p0[1], 1);

        // gapped stream with toggling data in the gaps
        cycle(1'b0, 1'b0, 1'b1);
        p0 = pulses;
        tog = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            logic [3:0] pat4;
            pat4 = 4'b1101;
            cycle(pat4[k], 1'b1, 1'b0);
            for (int g = 0; g < 3; g++) begin
                tog = ~tog;
                cycle(tog, 1'b0, 1'b0);
            end
        end
        chk("gap_pulses", 0, pulses[0] - p0[0], 1);
        chk("gap_count", 0, 32'(cnt_a), 1);

        // counter saturation: 1101 then 101 x7 gives 8 hits
        cycle(1'b0, 1'b0, 1'b1);
        p0 = pulses;
        send_bits(16'b1101, 4);
        for (int r = 0; r < 7; r++) send_bits(16'b101, 3);
        cycle(1'b0, 1'b0, 1'b0);
        chk("sat_count", 2, 32'(cnt_c), 7);
        chk("sat_flag", 2, 32'(s_c), 1);
        chk("sat_pulses", 2, pulses[2] - p0[2], 8);
        chk("wide_count", 0, 32'(cnt_a), 8);

        // clear together with the completing bit
        cycle(1'b0, 1'b0, 1'b1);
        p0 = pulses;
        send_bits(16'b110, 3);
        cycle(1'b1, 1'b1, 1'b1);
        chk("clr_match", 0, 32'(m_a), 0);
        chk("clr_count", 0, 32'(cnt_a), 0);
        chk("clr_armed", 0, 32'(ar_a), 0);
        send_bits(16'b1101, 4);
        cycle(1'b0, 1'b0, 1'b0);
        chk("clr_fresh_pulses", 0, pulses[0] - p0[0], 1);

        // asynchronous reset mid-window
        cycle(1'b0, 1'b0, 1'b1);
        send_bits(16'b1101, 4);
        send_bits(16'b110, 3);
        async_reset_pulse();
        chk("arst_match", 0, 32'(m_a), 0);
        chk("arst_count", 0, 32'(cnt_a), 0);
        chk("arst_armed", 0, 32'(ar_a), 0);
        chk("arst_sat", 2, 32'(s_c), 0);
        #1 rst_n_i = 1'b1;
        p0 = pulses;
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("arst_no_match", 0, pulses[0] - p0[0], 0);
        send_bits(16'b1101, 4);
        cycle(1'b0, 1'b0, 1'b0);
        chk("arst_then_match", 0, pulses[0] - p0[0], 1);

        // randomized stream
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(499, 0) == 0) begin
                async_reset_pulse();
                #1 rst_n_i = 1'b1;
            end
            cycle(1'($urandom_range(1, 0)),
                  1'($urandom_range(9, 0) < 7),
                  1'($urandom_range(255, 0) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
